// File: rtl/axi_to_jtag_s_axi_regs.sv
// AXI4-Lite register responder for the AXI-to-JTAG bridge.
// Holds four 32-bit registers at byte offsets 0x00-0x0C. It exposes their contents and
// one-cycle write strobes to the JTAG shift engine.
// Optional build macro AXI_TO_JTAG_REGS_SLVERR_EN: unmapped accesses answer SLVERR, not OKAY.
module axi_to_jtag_s_axi_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_wdata,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]       s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg0_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg1_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg2_out,
  output logic [C_S_AXI_DATA_WIDTH-1:0]       reg3_out,
  output logic [3:0]                          reg_wr_stb
);

  localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay = 2'b00;
`ifdef AXI_TO_JTAG_REGS_SLVERR_EN
  localparam logic [1:0] RespUnmapped = 2'b10;
`else
  localparam logic [1:0] RespUnmapped = 2'b00;
`endif

  typedef enum logic {StWIdle, StWResp} w_state_e;
  typedef enum logic {StRIdle, StRData} r_state_e;

  w_state_e w_state_q;
  r_state_e r_state_q;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];

  logic [1:0] aw_idx;
  logic [1:0] ar_idx;
  logic       aw_unmapped;
  logic       ar_unmapped;
  logic       aw_hs;
  logic       ar_hs;

  // Register index from addr[3:2]; any set bit from addr[4] up lands in the unmapped half.
  assign aw_idx      = s00_axi_awaddr[3:2];
  assign ar_idx      = s00_axi_araddr[3:2];
  assign aw_unmapped = |s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:4];
  assign ar_unmapped = |s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:4];
  assign aw_hs       = s00_axi_awready & s00_axi_awvalid & s00_axi_wvalid;
  assign ar_hs       = s00_axi_arready & s00_axi_arvalid;

  assign reg0_out = regs_q[0];
  assign reg1_out = regs_q[1];
  assign reg2_out = regs_q[2];
  assign reg3_out = regs_q[3];

  logic unused_inputs;
  assign unused_inputs = ^{s00_axi_awprot, s00_axi_arprot,
                           s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // Write FSM: joint AW/W acceptance, byte-masked register update, strobe and B response.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      w_state_q       <= StWIdle;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      s00_axi_bvalid  <= 1'b0;
      s00_axi_bresp   <= RespOkay;
      reg_wr_stb      <= '0;
      for (int k = 0; k < 4; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      reg_wr_stb      <= '0;
      s00_axi_awready <= 1'b0;
      s00_axi_wready  <= 1'b0;
      unique case (w_state_q)
        StWIdle: begin
          if (aw_hs) begin
            if (!aw_unmapped) begin
              for (int b = 0; b < NumBytes; b++) begin
                if (s00_axi_wstrb[b]) begin
                  regs_q[aw_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                end
              end
              // Strobe fires even for wstrb == 0 so the engine sees every mapped access.
              reg_wr_stb[aw_idx] <= 1'b1;
            end
            s00_axi_bresp  <= aw_unmapped ? RespUnmapped : RespOkay;
            s00_axi_bvalid <= 1'b1;
            w_state_q      <= StWResp;
          end else if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_awready) begin
            s00_axi_awready <= 1'b1;
            s00_axi_wready  <= 1'b1;
          end
        end
        StWResp: begin
          if (s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
            w_state_q      <= StWIdle;
          end
        end
        default: w_state_q <= StWIdle;
      endcase
    end
  end

  // Read FSM: one-cycle AR acceptance, data captured on the handshake edge, held until rready.
  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      r_state_q       <= StRIdle;
      s00_axi_arready <= 1'b0;
      s00_axi_rvalid  <= 1'b0;
      s00_axi_rdata   <= '0;
      s00_axi_rresp   <= RespOkay;
    end else begin
      s00_axi_arready <= 1'b0;
      unique case (r_state_q)
        StRIdle: begin
          if (ar_hs) begin
            // Sampled before any same-edge write lands, so a colliding read sees the old value.
            s00_axi_rdata  <= ar_unmapped ? '0 : regs_q[ar_idx];
            s00_axi_rresp  <= ar_unmapped ? RespUnmapped : RespOkay;
            s00_axi_rvalid <= 1'b1;
            r_state_q      <= StRData;
          end else if (s00_axi_arvalid && !s00_axi_arready) begin
            s00_axi_arready <= 1'b1;
          end
        end
        StRData: begin
          if (s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
            r_state_q      <= StRIdle;
          end
        end
        default: r_state_q <= StRIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_jtag_s_axi_regs.sv
// Scoreboard bench for axi_to_jtag_s_axi_regs: a register-array model predicts every B/R
// response and write strobe; monitors compare whenever the DUT completes a handshake.
`timescale 1ns/1ps
module tb_axi_to_jtag_s_axi_regs;

  localparam logic [1:0] Okay = 2'b00;
`ifdef AXI_TO_JTAG_REGS_SLVERR_EN
  localparam logic [1:0] UnmapResp = 2'b10;
`else
  localparam logic [1:0] UnmapResp = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] reg0, reg1, reg2, reg3;
  logic [3:0]  stb;

  always #5 clk = ~clk;

  axi_to_jtag_s_axi_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (areset),
    .s00_axi_awaddr (awaddr),
    .s00_axi_awprot (awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata  (wdata),
    .s00_axi_wstrb  (wstrb),
    .s00_axi_wvalid (wvalid),
    .s00_axi_wready (wready),
    .s00_axi_bresp  (bresp),
    .s00_axi_bvalid (bvalid),
    .s00_axi_bready (bready),
    .s00_axi_araddr (araddr),
    .s00_axi_arprot (arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata  (rdata),
    .s00_axi_rresp  (rresp),
    .s00_axi_rvalid (rvalid),
    .s00_axi_rready (rready),
    .reg0_out       (reg0),
    .reg1_out       (reg1),
    .reg2_out       (reg2),
    .reg3_out       (reg3),
    .reg_wr_stb     (stb)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] r0, r1, r2, r3;
  } b_exp_t;
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  logic [3:0]  exp_stb[$];
  logic [31:0] model[4];

  int n_checks = 0;
  int n_errors = 0;
  bit bp_hold  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ready generator: random backpressure unless a test holds both readies low.
  initial begin
    bready = 1'b0;
    rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      rready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // B monitor.
  always @(negedge clk) begin
    b_exp_t e;
    if (bvalid === 1'b1 && bready === 1'b1) begin
      if (exp_b.size() == 0) fail_now("b_unexpected");
      else begin
        e = exp_b.pop_front();
        check("bresp", {30'd0, bresp}, {30'd0, e.resp});
        check("reg0_out", reg0, e.r0);
        check("reg1_out", reg1, e.r1);
        check("reg2_out", reg2, e.r2);
        check("reg3_out", reg3, e.r3);
      end
    end
  end

  // R monitor.
  always @(negedge clk) begin
    r_exp_t e;
    if (rvalid === 1'b1 && rready === 1'b1) begin
      if (exp_r.size() == 0) fail_now("r_unexpected");
      else begin
        e = exp_r.pop_front();
        check("rdata", rdata, e.data);
        check("rresp", {30'd0, rresp}, {30'd0, e.resp});
      end
    end
  end

  // Strobe monitor: each nonzero cycle must match exactly one predicted pulse.
  always @(negedge clk) begin
    logic [3:0] e;
    if (stb !== 4'b0000 && !$isunknown(stb)) begin
      if (exp_stb.size() == 0) fail_now("stb_unexpected");
      else begin
        e = exp_stb.pop_front();
        check("reg_wr_stb", {28'd0, stb}, {28'd0, e});
      end
    end
  end

  task automatic wait_b();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) break;
      n++;
      if (n > 1000) begin
        fail_now("b_timeout");
        break;
      end
    end
    tick();
  endtask

  task automatic wait_r();
    int n = 0;
    forever begin
      @(negedge clk);
      if (rvalid && rready) break;
      n++;
      if (n > 1000) begin
        fail_now("r_timeout");
        break;
      end
    end
    tick();
  endtask

  // Write with W leading AW by 'skew' cycles; model updates at the predicted handshake.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int skew, input bit wait_done);
    int     idx;
    b_exp_t e;
    logic [3:0] oh;
    idx    = int'(a[3:2]);
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    awprot = 3'($urandom_range(0, 7));
    wvalid = 1'b1;
    for (int i = 0; i < skew; i++) begin
      check("skew_awready", {31'd0, awready}, 32'd0);
      check("skew_wready", {31'd0, wready}, 32'd0);
      tick();
    end
    awvalid = 1'b1;
    check("awready_early", {31'd0, awready}, 32'd0);
    tick();
    check("awready", {31'd0, awready}, 32'd1);
    check("wready", {31'd0, wready}, 32'd1);
    if (!a[4]) begin
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      oh = 4'b0001 << idx;
      exp_stb.push_back(oh);
    end
    e.resp = a[4] ? UnmapResp : Okay;
    e.r0 = model[0];
    e.r1 = model[1];
    e.r2 = model[2];
    e.r3 = model[3];
    exp_b.push_back(e);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("bvalid", {31'd0, bvalid}, 32'd1);
    check("awready_drop", {31'd0, awready}, 32'd0);
    if (wait_done) wait_b();
  endtask

  task automatic do_read(input logic [4:0] a, input bit wait_done);
    r_exp_t e;
    e.data = a[4] ? 32'd0 : model[int'(a[3:2])];
    e.resp = a[4] ? UnmapResp : Okay;
    exp_r.push_back(e);
    araddr  = a;
    arprot  = 3'($urandom_range(0, 7));
    arvalid = 1'b1;
    check("arready_early", {31'd0, arready}, 32'd0);
    tick();
    check("arready", {31'd0, arready}, 32'd1);
    tick();
    arvalid = 1'b0;
    check("rvalid", {31'd0, rvalid}, 32'd1);
    check("arready_drop", {31'd0, arready}, 32'd0);
    if (wait_done) wait_r();
  endtask

  task automatic hold_ready(input bit h);
    bp_hold = h;
    repeat (2) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_data;
    areset  = 1'b1;
    awaddr  = '0; awprot = '0; awvalid = 1'b0;
    wdata   = '0; wstrb  = '0; wvalid  = 1'b0;
    araddr  = '0; arprot = '0; arvalid = 1'b0;
    for (int k = 0; k < 4; k++) model[k] = '0;
    repeat (3) tick();
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_stb", {28'd0, stb}, 32'd0);
    check("rst_bresp", {30'd0, bresp}, 32'd0);
    check("rst_rresp", {30'd0, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_regs", reg0 | reg1 | reg2 | reg3, 32'd0);
    areset = 1'b0;
    tick();

    // Sequential write then read-back.
    for (int i = 0; i < 4; i++) do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 1'b1);
    for (int i = 0; i < 4; i++) do_read(5'(4 * i), 1'b1);

    // Byte strobes on reg1.
    do_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 1'b1);
    do_write(5'h04, 32'h11223344, 4'b0101, 0, 1'b1);
    check("byte_merge", reg1, 32'hAA22CC44);
    do_read(5'h04, 1'b1);

    // W leads AW by five cycles.
    do_write(5'h08, 32'h0BADF00D, 4'hF, 5, 1'b1);

    // Write backpressure while a second write is offered.
    hold_ready(1'b1);
    do_write(5'h0C, 32'hCAFEF00D, 4'hF, 0, 1'b0);
    awaddr = 5'h00; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    repeat (10) begin
      tick();
      check("bp_bvalid", {31'd0, bvalid}, 32'd1);
      check("bp_bresp", {30'd0, bresp}, {30'd0, Okay});
      check("bp_awready", {31'd0, awready | wready}, 32'd0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bp_hold = 1'b0;
    wait_b();

    // Read backpressure while a second read is offered.
    hold_ready(1'b1);
    hold_data = model[3];
    do_read(5'h0C, 1'b0);
    araddr = 5'h00; arvalid = 1'b1;
    repeat (10) begin
      tick();
      check("bp_rvalid", {31'd0, rvalid}, 32'd1);
      check("bp_rdata", rdata, hold_data);
      check("bp_arready", {31'd0, arready}, 32'd0);
    end
    arvalid = 1'b0;
    bp_hold = 1'b0;
    wait_r();

    // Unmapped write and read.
    do_write(5'h10, 32'h5A5A5A5A, 4'hF, 0, 1'b1);
    do_read(5'h10, 1'b1);

    // Same-register read and write on the same edge: read sees the old value.
    fork
      do_write(5'h00, 32'h13572468, 4'hF, 0, 1'b1);
      do_read(5'h00, 1'b1);
    join

    // Randomized traffic, including concurrent read/write pairs and wstrb == 0.
    for (int it = 0; it < 80; it++) begin
      int          op, skew;
      logic [4:0]  wa, ra;
      logic [31:0] wd;
      logic [3:0]  ws;
      op   = $urandom_range(0, 2);
      skew = $urandom_range(0, 3);
      wa   = 5'($urandom_range(0, 31));
      ra   = 5'($urandom_range(0, 31));
      wd   = $urandom;
      ws   = 4'($urandom_range(0, 15));
      if (op == 0) do_write(wa, wd, ws, skew, 1'b1);
      else if (op == 1) do_read(ra, 1'b1);
      else begin
        fork
          do_write(wa, wd, ws, skew, 1'b1);
          do_read(ra, 1'b1);
        join
      end
    end

    // Reset while a write response is pending.
    hold_ready(1'b1);
    do_write(5'h08, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    areset = 1'b1;
    exp_b.delete();
    for (int k = 0; k < 4; k++) model[k] = '0;
    tick();
    areset = 1'b0;
    check("rst_mid_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_mid_reg2", reg2, 32'd0);
    bp_hold = 1'b0;
    do_read(5'h08, 1'b1);

    repeat (5) tick();
    check("b_queue_drained", exp_b.size(), 32'd0);
    check("r_queue_drained", exp_r.size(), 32'd0);
    check("stb_queue_drained", exp_stb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
